// File: rtl/atmega_pp_pkg.sv
// atmega_pp_pkg
//   Shared constants for the ATmega high-voltage parallel programming
//   sequencer: command opcodes, {XA1,XA0} encodings, FSM state encodings
//   and small decode helpers used when a command is accepted.
//   No ports (package).

package atmega_pp_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [2:0] OP_LOAD_CMD     = 3'd0;
    localparam logic [2:0] OP_LOAD_ADDR_LO = 3'd1;
    localparam logic [2:0] OP_LOAD_ADDR_HI = 3'd2;
    localparam logic [2:0] OP_LOAD_DATA_LO = 3'd3;
    localparam logic [2:0] OP_LOAD_DATA_HI = 3'd4;
    localparam logic [2:0] OP_LATCH_PAGE   = 3'd5;
    localparam logic [2:0] OP_PROGRAM      = 3'd6;
    localparam logic [2:0] OP_READ         = 3'd7;

    // {XA1, XA0} encodings for the XTAL-strobed load operations
    localparam logic [1:0] XA_ADDR = 2'b00;
    localparam logic [1:0] XA_DATA = 2'b01;
    localparam logic [1:0] XA_CMD  = 2'b10;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_SETUP_ENC    = 3'd1;
    localparam logic [2:0] ST_PULSE_ENC    = 3'd2;
    localparam logic [2:0] ST_HOLD_ENC     = 3'd3;
    localparam logic [2:0] ST_WAIT_RDY_ENC = 3'd4;
    localparam logic [2:0] ST_DONE_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_SETUP    = ST_SETUP_ENC,
        ST_PULSE    = ST_PULSE_ENC,
        ST_HOLD     = ST_HOLD_ENC,
        ST_WAIT_RDY = ST_WAIT_RDY_ENC,
        ST_DONE     = ST_DONE_ENC
    } pp_state_t;

    // Opcodes 0..4 are XTAL-strobed loads that drive the data bus
    function automatic logic is_load(input logic [2:0] op);
        return (op <= OP_LOAD_DATA_HI);
    endfunction

    // {XA1, XA0} for an opcode; non-load opcodes leave XA at 00
    function automatic logic [1:0] xa_for(input logic [2:0] op);
        case (op)
            OP_LOAD_CMD:                     return XA_CMD;
            OP_LOAD_DATA_LO, OP_LOAD_DATA_HI: return XA_DATA;
            default:                         return XA_ADDR;
        endcase
    endfunction

    // {BS2, BS1} for an opcode and its select byte
    function automatic logic [1:0] bs_for(input logic [2:0] op, input logic [7:0] data);
        case (op)
            OP_LOAD_ADDR_HI, OP_LOAD_DATA_HI: return 2'b01;
            OP_LATCH_PAGE:                    return {1'b0, data[0]};
            OP_PROGRAM, OP_READ:              return data[1:0];
            default:                          return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/atmega_pp_sequencer_if.sv
// atmega_pp_sequencer_if
//   Command/response channel between the host register decoder (master)
//   and the programming sequencer (slave).
//   cmd_valid/cmd_op/cmd_data : command from host, accepted on valid && ready
//   cmd_ready                 : sequencer idle
//   rsp_valid                 : one-cycle completion pulse
//   rsp_data                  : byte sampled by READ
//   rsp_timeout               : RDY wait expired (qualifies rsp_valid)

interface atmega_pp_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );
endinterface

// File: rtl/pp_sync2.sv
// pp_sync2
//   Two-flop synchronizer for the asynchronous DUT RDY/BSY pin.
//   Resets to 1 so that an undriven or idle RDY reads as "ready".
//   clk : sampling clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output

module pp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/atmega_pp_sequencer.sv
// atmega_pp_sequencer
//   Executes one high-voltage parallel programming primitive per command:
//   sets XA/BS/data, waits SETUP_CYCLES, asserts the opcode's strobe for
//   PULSE_CYCLES, holds for PULSE_CYCLES, optionally waits on RDY/BSY
//   (PROGRAM), then pulses rsp_valid for one cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   cmd           : command/response channel (slave side)
//   dut_xtal, dut_pagel, dut_bs1, dut_bs2, dut_xa0, dut_xa1 : active-high pins
//   dut_oe_n, dut_wr_n : active-low pins
//   dut_data_out, dut_data_oe : data bus drive and its enable
//   dut_data_in   : data bus read-back
//   dut_rdy       : RDY/BSY pin (asynchronous)

module atmega_pp_sequencer
    import atmega_pp_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned BUSY_TIMEOUT = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    atmega_pp_sequencer_if.slave       cmd,
    output logic                       dut_xtal,
    output logic                       dut_pagel,
    output logic                       dut_bs1,
    output logic                       dut_bs2,
    output logic                       dut_xa0,
    output logic                       dut_xa1,
    output logic                       dut_oe_n,
    output logic                       dut_wr_n,
    output logic [7:0]                 dut_data_out,
    output logic                       dut_data_oe,
    input  logic [7:0]                 dut_data_in,
    input  logic                       dut_rdy
);
    localparam logic [7:0]  SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0]  PULSE_LAST  = 8'(PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_MAX = 16'(BUSY_TIMEOUT);

    pp_state_t   state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] tcnt, tcnt_n;
    logic        timed_out;
    logic        accept;
    logic        rdy_sync;

    logic [2:0]  op_q;
    logic [7:0]  rd_byte;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_timeout_q;

    pp_sync2 u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_rdy),
        .q   (rdy_sync)
    );

    assign accept          = cmd.cmd_valid && (state == ST_IDLE);
    assign cmd.cmd_ready   = (state == ST_IDLE);
    assign cmd.rsp_valid   = rsp_valid_q;
    assign cmd.rsp_data    = rsp_data_q;
    assign cmd.rsp_timeout = rsp_timeout_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tcnt_n    = tcnt;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SETUP;
                    cnt_n   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = ST_PULSE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == PULSE_LAST) begin
                    cnt_n   = '0;
                    tcnt_n  = '0;
                    state_n = (op_q == OP_PROGRAM) ? ST_WAIT_RDY : ST_DONE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_WAIT_RDY: begin
                // tcnt counts wait cycles already spent; it saturates rather
                // than wrapping. The first two cycles ignore RDY because the
                // synchronizer still shows the level from before the pulse.
                if (tcnt != TIMEOUT_MAX) begin
                    tcnt_n = tcnt + 16'd1;
                end
                if ((tcnt >= 16'd2) && rdy_sync) begin
                    state_n = ST_DONE;
                end else if (tcnt_n == TIMEOUT_MAX) begin
                    state_n   = ST_DONE;
                    timed_out = 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so strobes are
    // glitch-free and line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tcnt          <= '0;
            op_q          <= '0;
            rd_byte       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            dut_xtal      <= 1'b0;
            dut_pagel     <= 1'b0;
            dut_bs1       <= 1'b0;
            dut_bs2       <= 1'b0;
            dut_xa0       <= 1'b0;
            dut_xa1       <= 1'b0;
            dut_oe_n      <= 1'b1;
            dut_wr_n      <= 1'b1;
            dut_data_out  <= '0;
            dut_data_oe   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tcnt  <= tcnt_n;

            if (accept) begin
                op_q               <= cmd.cmd_op;
                {dut_xa1, dut_xa0} <= xa_for(cmd.cmd_op);
                {dut_bs2, dut_bs1} <= bs_for(cmd.cmd_op, cmd.cmd_data);
                dut_data_out       <= is_load(cmd.cmd_op) ? cmd.cmd_data : '0;
                dut_data_oe        <= is_load(cmd.cmd_op);
            end else if (state == ST_DONE) begin
                {dut_xa1, dut_xa0} <= '0;
                {dut_bs2, dut_bs1} <= '0;
                dut_data_out       <= '0;
                dut_data_oe        <= 1'b0;
            end

            dut_xtal  <= (state_n == ST_PULSE) && is_load(op_q);
            dut_pagel <= (state_n == ST_PULSE) && (op_q == OP_LATCH_PAGE);
            dut_wr_n  <= !((state_n == ST_PULSE) && (op_q == OP_PROGRAM));
            dut_oe_n  <= !(((state_n == ST_PULSE) || (state_n == ST_HOLD)) &&
                           (op_q == OP_READ));

            // Read data is captured on the final PULSE cycle but only
            // published at DONE so rsp_data stays stable between responses.
            if ((state == ST_PULSE) && (cnt == PULSE_LAST) && (op_q == OP_READ)) begin
                rd_byte <= dut_data_in;
            end

            rsp_valid_q <= (state_n == ST_DONE);
            if (state_n == ST_DONE) begin
                rsp_data_q    <= (op_q == OP_READ) ? rd_byte : '0;
                rsp_timeout_q <= timed_out;
            end
        end
    end
endmodule

// File: tb/tb_atmega_pp_sequencer.sv
`timescale 1ns/1ps
// tb_atmega_pp_sequencer
//   Directed bench with a response scoreboard. Instance u_dut uses default
//   parameters; u_dut_to uses BUSY_TIMEOUT = 50 for the RDY-stuck case.

module tb_atmega_pp_sequencer;
    import atmega_pp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned tests = 0;
    int unsigned fails = 0;

    atmega_pp_sequencer_if ifa ();
    atmega_pp_sequencer_if ifb ();

    logic       xtal_a, pagel_a, bs1_a, bs2_a, xa0_a, xa1_a, oe_n_a, wr_n_a;
    logic [7:0] data_out_a;
    logic       data_oe_a;
    logic [7:0] data_in_a = 8'h00;
    logic       rdy_a = 1'b1;

    logic       xtal_b, pagel_b, bs1_b, bs2_b, xa0_b, xa1_b, oe_n_b, wr_n_b;
    logic [7:0] data_out_b;
    logic       data_oe_b;
    logic [7:0] data_in_b = 8'h00;
    logic       rdy_b = 1'b0;

    atmega_pp_sequencer u_dut (
        .clk(clk), .rst(rst), .cmd(ifa),
        .dut_xtal(xtal_a), .dut_pagel(pagel_a), .dut_bs1(bs1_a), .dut_bs2(bs2_a),
        .dut_xa0(xa0_a), .dut_xa1(xa1_a), .dut_oe_n(oe_n_a), .dut_wr_n(wr_n_a),
        .dut_data_out(data_out_a), .dut_data_oe(data_oe_a),
        .dut_data_in(data_in_a), .dut_rdy(rdy_a)
    );

    atmega_pp_sequencer #(.BUSY_TIMEOUT(50)) u_dut_to (
        .clk(clk), .rst(rst), .cmd(ifb),
        .dut_xtal(xtal_b), .dut_pagel(pagel_b), .dut_bs1(bs1_b), .dut_bs2(bs2_b),
        .dut_xa0(xa0_b), .dut_xa1(xa1_b), .dut_oe_n(oe_n_b), .dut_wr_n(wr_n_b),
        .dut_data_out(data_out_b), .dut_data_oe(data_oe_b),
        .dut_data_in(data_in_b), .dut_rdy(rdy_b)
    );

    typedef struct {
        logic [7:0]  data;
        logic        check_data;
        logic        timeout;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {xtal, pagel, bs1, bs2, xa0, xa1, oe_n, wr_n}
    function automatic logic [7:0] pins_a();
        return {xtal_a, pagel_a, bs1_a, bs2_a, xa0_a, xa1_a, oe_n_a, wr_n_a};
    endfunction

    // Response monitor: pops and compares whenever a DUT presents rsp_valid
    always @(negedge clk) begin
        exp_t e;
        if (ifa.rsp_valid) begin
            chk("rsp_a_expected", qa.size() != 0, 1'b1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("rsp_a_cycle", cyc, e.cyc);
                chk("rsp_a_timeout", ifa.rsp_timeout, e.timeout);
                if (e.check_data) chk("rsp_a_data", ifa.rsp_data, e.data);
            end
        end
        if (ifb.rsp_valid) begin
            chk("rsp_b_expected", qb.size() != 0, 1'b1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("rsp_b_cycle", cyc, e.cyc);
                chk("rsp_b_timeout", ifb.rsp_timeout, e.timeout);
                if (e.check_data) chk("rsp_b_data", ifb.rsp_data, e.data);
            end
        end
    end

    // Presents a command and returns after the accept edge; acc is the cycle
    // count of cycle 1. With hold set, cmd_valid is left asserted.
    task automatic issue(input bit sel, input logic [2:0] op, input logic [7:0] data,
                         input bit hold, output int unsigned acc);
        bit done = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        if (sel) begin
            ifb.cmd_op = op; ifb.cmd_data = data; ifb.cmd_valid = 1'b1;
        end else begin
            ifa.cmd_op = op; ifa.cmd_data = data; ifa.cmd_valid = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sel ? ifb.cmd_ready : ifa.cmd_ready) begin
                @(posedge clk); #1;
                acc  = cyc;
                done = 1'b1;
            end
        end
        chk("accept", done, 1'b1);
        if (!hold) begin
            if (sel) ifb.cmd_valid = 1'b0; else ifa.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit sel);
        int i = 0;
        while ((sel ? qb.size() : qa.size()) != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk(sel ? "drain_b" : "drain_a", sel ? qb.size() : qa.size(), 0);
    endtask

    // Runs a non-PROGRAM command on u_dut, checking pins for cycles 1..12
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                           input logic [7:0] busy_vec, input logic [7:0] act_vec,
                           input int unsigned act_first, input int unsigned act_last,
                           input logic [8:0] dexp, input bit chk_rd, input logic [7:0] rd_exp);
        int unsigned acc;
        if (chk_rd) data_in_a = 8'h11;
        issue(1'b0, op, data, 1'b0, acc);
        qa.push_back('{data: rd_exp, check_data: chk_rd, timeout: 1'b0, cyc: acc + 10});
        for (int unsigned n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (chk_rd && n == 6) data_in_a = rd_exp;
            if (chk_rd && n == 7) data_in_a = ~rd_exp;
            if (n == 12) begin
                chk("pins_idle@12", pins_a(), 8'b0000_0011);
                chk("data_idle@12", {data_oe_a, data_out_a}, 9'h000);
                chk("ready_back@12", ifa.cmd_ready, 1'b1);
            end else begin
                chk($sformatf("pins@%0d", n), pins_a(),
                    (n >= act_first && n <= act_last) ? act_vec : busy_vec);
                chk($sformatf("data@%0d", n), {data_oe_a, data_out_a}, dexp);
                chk($sformatf("ready_busy@%0d", n), ifa.cmd_ready, 1'b0);
            end
        end
        drain(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int unsigned acc;
        ifa.cmd_valid = 1'b0; ifa.cmd_op = '0; ifa.cmd_data = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = '0; ifb.cmd_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset / idle levels
        chk("rst_ready_a", ifa.cmd_ready, 1'b1);
        chk("rst_ready_b", ifb.cmd_ready, 1'b1);
        chk("rst_rsp", {ifa.rsp_valid, ifa.rsp_timeout, ifa.rsp_data}, 10'h000);
        chk("rst_pins", pins_a(), 8'b0000_0011);
        chk("rst_data", {data_oe_a, data_out_a}, 9'h000);

        // LOAD_ADDR_LO 0x5A: XA=00 BS1=0, xtal cycles 3..6
        run_cmd(OP_LOAD_ADDR_LO, 8'h5A, 8'b0000_0011, 8'b1000_0011, 3, 6, 9'h15A, 1'b0, 8'h00);

        // LATCH_PAGE 0x01: pagel cycles 3..6, BS1=1, no data drive
        run_cmd(OP_LATCH_PAGE, 8'h01, 8'b0010_0011, 8'b0110_0011, 3, 6, 9'h000, 1'b0, 8'h00);

        // READ 0x02: BS2=1, oe_n low cycles 3..10, sample on cycle 6
        run_cmd(OP_READ, 8'h02, 8'b0001_0011, 8'b0001_0001, 3, 10, 9'h000, 1'b1, 8'hC3);
        chk("rsp_data_hold", ifa.rsp_data, 8'hC3);

        // PROGRAM 0x01: wr_n low cycles 3..6, BS1=1, RDY low for 100 cycles
        rdy_a = 1'b0;
        issue(1'b0, OP_PROGRAM, 8'h01, 1'b0, acc);
        for (int unsigned n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n <= 12) begin
                chk($sformatf("prog_pins@%0d", n), pins_a(),
                    (n >= 3 && n <= 6) ? 8'b0010_0010 : 8'b0010_0011);
                chk($sformatf("prog_data@%0d", n), {data_oe_a, data_out_a}, 9'h000);
            end
        end
        chk("prog_still_busy", ifa.cmd_ready, 1'b0);
        rdy_a = 1'b1;
        qa.push_back('{data: 8'h00, check_data: 1'b0, timeout: 1'b0, cyc: cyc + 3});
        drain(1'b0);

        // PROGRAM on the BUSY_TIMEOUT=50 instance with RDY stuck low
        issue(1'b1, OP_PROGRAM, 8'h00, 1'b0, acc);
        qb.push_back('{data: 8'h00, check_data: 1'b0, timeout: 1'b1, cyc: acc + 60});
        drain(1'b1);

        // Held command during busy, accepted back-to-back
        issue(1'b0, OP_LOAD_CMD, 8'hA5, 1'b1, acc);
        ifa.cmd_op   = OP_LOAD_DATA_LO;
        ifa.cmd_data = 8'h33;
        qa.push_back('{data: 8'h00, check_data: 1'b0, timeout: 1'b0, cyc: acc + 10});
        qa.push_back('{data: 8'h00, check_data: 1'b0, timeout: 1'b0, cyc: acc + 22});
        for (int unsigned n = 1; n <= 13; n++) begin
            @(negedge clk);
            if (n <= 11) begin
                chk($sformatf("b2b_pins@%0d", n), pins_a(),
                    (n >= 3 && n <= 6) ? 8'b1000_0111 : 8'b0000_0111);
                chk($sformatf("b2b_data@%0d", n), {data_oe_a, data_out_a}, 9'h1A5);
                chk($sformatf("b2b_busy@%0d", n), ifa.cmd_ready, 1'b0);
            end else if (n == 12) begin
                chk("b2b_gap_ready", ifa.cmd_ready, 1'b1);
                chk("b2b_gap_data", {data_oe_a, data_out_a}, 9'h000);
            end else begin
                chk("b2b_second_ready", ifa.cmd_ready, 1'b0);
                chk("b2b_second_pins", pins_a(), 8'b0000_1011);
                chk("b2b_second_data", {data_oe_a, data_out_a}, 9'h133);
            end
        end
        ifa.cmd_valid = 1'b0;
        drain(1'b0);

        // Reset during PULSE of LOAD_DATA_HI
        issue(1'b0, OP_LOAD_DATA_HI, 8'h77, 1'b0, acc);
        qa.push_back('{data: 8'h00, check_data: 1'b0, timeout: 1'b0, cyc: acc + 10});
        repeat (4) @(negedge clk);
        chk("mid_xtal_high", xtal_a, 1'b1);
        rst = 1'b1;
        #1;
        qa.delete();
        chk("mid_rst_pins", pins_a(), 8'b0000_0011);
        chk("mid_rst_data", {data_oe_a, data_out_a}, 9'h000);
        chk("mid_rst_ready", ifa.cmd_ready, 1'b1);
        chk("mid_rst_rsp", ifa.rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", ifa.cmd_ready, 1'b1);
        repeat (15) @(negedge clk);
        run_cmd(OP_LOAD_DATA_HI, 8'h77, 8'b0010_1011, 8'b1010_1011, 3, 6, 9'h177, 1'b0, 8'h00);

        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
